// File: rtl/rtu_rob_ctrl.sv
// rtu_rob_ctrl: ROB tail/head/count sequencing with flush -> recover state machine
module rtu_rob_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int PTR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_clk,
  input  logic                 idu_create_req,
  input  logic                 ext_flush_req,
  input  logic [ENTRY_NUM-1:0] entry_retire_vld,
  input  logic [ENTRY_NUM-1:0] entry_flush_vld,
  output logic [ENTRY_NUM-1:0] rob_create_sel,
  output logic [ENTRY_NUM-1:0] head_iid_ptr_cur_vld,
  output logic [PTR_W-1:0]     create_iid,
  output logic [PTR_W-1:0]     head_iid,
  output logic [PTR_W:0]       entry_cnt,
  output logic                 rob_full,
  output logic                 rob_empty,
  output logic                 rtu_idu_stall,
  output logic                 rtu_global_flush,
  output logic                 retire_err
);
  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;
  state_t state, state_nxt;
  logic [PTR_W-1:0] tail, head;
  logic [PTR_W:0] cnt;
  logic [ENTRY_NUM-1:0] head_oh;
  logic flush_trig, run, create_acc, ret_acc, err_cond;
  always_comb begin
    run = state == RUN;
    flush_trig = |entry_flush_vld | ext_flush_req;
    state_nxt = run ? (flush_trig ? FLUSH : RUN) : state == FLUSH ? RECOVER : RUN;
    head_oh = ENTRY_NUM'(1) << head;
    rob_full = cnt == (PTR_W+1)'(ENTRY_NUM);
    rob_empty = cnt == '0;
    create_acc = idu_create_req & run & ~rob_full & ~flush_trig;
    ret_acc = entry_retire_vld[head] & run & ~rob_empty;
    err_cond = |(entry_retire_vld & ~head_oh) | (rob_empty & |entry_retire_vld);
    rob_create_sel = create_acc ? ENTRY_NUM'(1) << tail : '0;
    head_iid_ptr_cur_vld = run ? head_oh : '0;
    create_iid = tail;
    head_iid = head;
    entry_cnt = cnt;
    rtu_idu_stall = rob_full | ~run | flush_trig;
    rtu_global_flush = state == FLUSH;
  end
  always_ff @(posedge clk) begin
    if (rst_clk) begin
      state <= RUN;
      tail <= '0;
      head <= '0;
      cnt <= '0;
      retire_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_cond) retire_err <= 1'b1;
      if (state == FLUSH) begin
        tail <= '0;
        head <= '0;
        cnt <= '0;
      end else begin
        tail <= tail + PTR_W'(create_acc);
        head <= head + PTR_W'(ret_acc);
        cnt <= cnt + (PTR_W+1)'(create_acc) - (PTR_W+1)'(ret_acc);
      end
    end
  end
endmodule

// File: tb/tb_rtu_rob_ctrl.sv
// tb_rtu_rob_ctrl: directed self-checking bench for rtu_rob_ctrl
module tb_rtu_rob_ctrl;
  logic clk = 0, rst_clk = 1, idu_create_req = 0, ext_flush_req = 0;
  logic [7:0] entry_retire_vld = 0, entry_flush_vld = 0;
  logic [7:0] rob_create_sel, head_iid_ptr_cur_vld;
  logic [2:0] create_iid, head_iid;
  logic [3:0] entry_cnt;
  logic rob_full, rob_empty, rtu_idu_stall, rtu_global_flush, retire_err;
  int errors = 0, checks = 0;
  rtu_rob_ctrl #(.ENTRY_NUM(8), .PTR_W(3)) dut (
    .clk(clk), .rst_clk(rst_clk), .idu_create_req(idu_create_req), .ext_flush_req(ext_flush_req),
    .entry_retire_vld(entry_retire_vld), .entry_flush_vld(entry_flush_vld),
    .rob_create_sel(rob_create_sel), .head_iid_ptr_cur_vld(head_iid_ptr_cur_vld),
    .create_iid(create_iid), .head_iid(head_iid), .entry_cnt(entry_cnt),
    .rob_full(rob_full), .rob_empty(rob_empty), .rtu_idu_stall(rtu_idu_stall),
    .rtu_global_flush(rtu_global_flush), .retire_err(retire_err));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    rst_clk = 0;
    ext_flush_req = 1;
    idu_create_req = 1;
    #1;
    chk("pre_flush_stall", rtu_idu_stall, 1);
    chk("pre_flush_nocreate", rob_create_sel, 0);
    tick;
    ext_flush_req = 0;
    idu_create_req = 0;
    chk("in_flush_gflush", rtu_global_flush, 1);
    chk("in_flush_headvld", head_iid_ptr_cur_vld, 0);
    rst_clk = 1;
    tick;
    tick;
    rst_clk = 0;
    #1;
    chk("rst_gflush", rtu_global_flush, 0);
    chk("rst_cnt", entry_cnt, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_stall", rtu_idu_stall, 0);
    chk("rst_headvld", head_iid_ptr_cur_vld, 8'h01);
    chk("rst_sel", rob_create_sel, 0);
    chk("rst_err", retire_err, 0);
    tick;
    chk("rst_run_gflush", rtu_global_flush, 0);
    chk("rst_run_headvld", head_iid_ptr_cur_vld, 8'h01);
    for (int i = 0; i < 8; i++) begin
      idu_create_req = 1;
      #1;
      chk($sformatf("fill_sel%0d", i), rob_create_sel, 32'h1 << i);
      chk($sformatf("fill_iid%0d", i), create_iid, i);
      tick;
    end
    chk("fill_full", rob_full, 1);
    chk("fill_cnt", entry_cnt, 8);
    chk("fill_empty", rob_empty, 0);
    #1;
    chk("ninth_sel", rob_create_sel, 0);
    chk("ninth_stall", rtu_idu_stall, 1);
    tick;
    chk("ninth_cnt", entry_cnt, 8);
    entry_retire_vld = 8'h01;
    #1;
    chk("full_ret_sel", rob_create_sel, 0);
    tick;
    idu_create_req = 0;
    chk("first_ret_cnt", entry_cnt, 7);
    chk("first_ret_tail", create_iid, 0);
    for (int i = 1; i < 6; i++) begin
      entry_retire_vld = 8'h1 << i;
      tick;
    end
    entry_retire_vld = 0;
    chk("ret6_cnt", entry_cnt, 2);
    chk("ret6_head", head_iid, 6);
    for (int i = 0; i < 6; i++) begin
      idu_create_req = 1;
      #1;
      chk($sformatf("wrap_iid%0d", i), create_iid, i);
      tick;
    end
    idu_create_req = 0;
    chk("wrap_tail", create_iid, 6);
    chk("wrap_head", head_iid, 6);
    chk("wrap_cnt", entry_cnt, 8);
    chk("wrap_full", rob_full, 1);
    chk("wrap_headvld", head_iid_ptr_cur_vld, 8'h40);
    for (int i = 0; i < 5; i++) begin
      entry_retire_vld = 8'h1 << ((6 + i) % 8);
      tick;
    end
    chk("cnt3", entry_cnt, 3);
    chk("cnt3_head", head_iid, 3);
    entry_retire_vld = 8'h08;
    idu_create_req = 1;
    #1;
    chk("both_sel", rob_create_sel, 8'h40);
    tick;
    entry_retire_vld = 0;
    idu_create_req = 0;
    chk("both_cnt", entry_cnt, 3);
    chk("both_head", head_iid, 4);
    chk("both_tail", create_iid, 7);
    chk("both_err", retire_err, 0);
    entry_flush_vld = 8'h04;
    idu_create_req = 1;
    #1;
    chk("fN_stall", rtu_idu_stall, 1);
    chk("fN_sel", rob_create_sel, 0);
    chk("fN_gflush", rtu_global_flush, 0);
    tick;
    entry_flush_vld = 0;
    ext_flush_req = 1;
    #1;
    chk("fN1_gflush", rtu_global_flush, 1);
    chk("fN1_stall", rtu_idu_stall, 1);
    chk("fN1_sel", rob_create_sel, 0);
    tick;
    ext_flush_req = 0;
    #1;
    chk("fN2_gflush", rtu_global_flush, 0);
    chk("fN2_stall", rtu_idu_stall, 1);
    chk("fN2_head", head_iid, 0);
    chk("fN2_tail", create_iid, 0);
    chk("fN2_cnt", entry_cnt, 0);
    chk("fN2_empty", rob_empty, 1);
    chk("fN2_sel", rob_create_sel, 0);
    tick;
    chk("fN3_stall", rtu_idu_stall, 0);
    chk("fN3_sel", rob_create_sel, 8'h01);
    chk("fN3_gflush", rtu_global_flush, 0);
    chk("fN3_headvld", head_iid_ptr_cur_vld, 8'h01);
    tick;
    chk("fN4_cnt", entry_cnt, 1);
    chk("fN4_tail", create_iid, 1);
    tick;
    tick;
    idu_create_req = 0;
    entry_retire_vld = 8'h01;
    tick;
    entry_retire_vld = 8'h02;
    tick;
    entry_retire_vld = 0;
    chk("err_pre_head", head_iid, 2);
    chk("err_pre_cnt", entry_cnt, 1);
    chk("err_pre", retire_err, 0);
    entry_retire_vld = 8'h20;
    tick;
    entry_retire_vld = 0;
    chk("err_head", head_iid, 2);
    chk("err_set", retire_err, 1);
    chk("err_cnt", entry_cnt, 1);
    entry_retire_vld = 8'h04;
    tick;
    chk("err_ok_head", head_iid, 3);
    chk("err_sticky", retire_err, 1);
    chk("err_ok_cnt", entry_cnt, 0);
    entry_retire_vld = 8'h08;
    tick;
    entry_retire_vld = 0;
    chk("empty_ret_head", head_iid, 3);
    chk("empty_ret_cnt", entry_cnt, 0);
    tick;
    chk("err_sticky2", retire_err, 1);
    rst_clk = 1;
    tick;
    rst_clk = 0;
    chk("err_clr", retire_err, 0);
    chk("err_clr_head", head_iid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rtu_rob_ctrl.md
Name: rtu_rob_ctrl

Overview:
- Sequencing controller for the reorder buffer: a circular array of ENTRY_NUM rtu_rob_entry instances.
- Owns the tail (allocation) pointer, the head (retire) pointer, the occupancy count and the full/empty flags.
- Drives each entry's one-hot create select and head-valid line.
- Turns any entry's flush request, or an external flush request, into a single-cycle rtu_global_flush followed by a one-cycle recovery stall.

Parameters:
- ENTRY_NUM, 8: number of ROB entries. Must be a power of two, ≥2.
- PTR_W, 3: pointer width. Must equal log2(ENTRY_NUM).

Ports:
- clk  input  1  clock. Single clock domain.
- rst_clk  input  1  reset. Synchronous, active-high: sampled on posedge clk, 1 = reset.
- idu_create_req  input  1  decode requests allocation of one entry this cycle.
- ext_flush_req  input  1  external flush request (exception/interrupt path).
- entry_retire_vld  input  ENTRY_NUM  per-entry retire_vld.
- entry_flush_vld  input  ENTRY_NUM  per-entry flush_vld.
- rob_create_sel  output  ENTRY_NUM  one-hot create_vld to the entries.
- head_iid_ptr_cur_vld  output  ENTRY_NUM  one-hot head marker to the entries.
- create_iid  output  PTR_W  index of the entry allocated this cycle (equals the tail pointer).
- head_iid  output  PTR_W  current head pointer.
- entry_cnt  output  PTR_W+1  occupancy, range 0..ENTRY_NUM.
- rob_full  output  1  entry_cnt == ENTRY_NUM.
- rob_empty  output  1  entry_cnt == 0.
- rtu_idu_stall  output  1  decode must not request allocation.
- rtu_global_flush  output  1  flush broadcast to the entries and the front end.
- retire_err  output  1  sticky protocol error.

Behaviour:
- State machine, registered:
  - RUN → FLUSH when (|entry_flush_vld | ext_flush_req).
  - FLUSH → RECOVER unconditionally.
  - RECOVER → RUN unconditionally.
  - Reset state is RUN.
- Reset (rst_clk = 1 at posedge) forces the following, overriding all other inputs including mid-flush:
  - tail = 0, head = 0, cnt = 0, state = RUN, retire_err = 0, rtu_global_flush = 0.
  - Consequently rob_empty = 1, rob_full = 0, rtu_idu_stall = 0, rob_create_sel = 0, head_iid_ptr_cur_vld = one-hot bit 0.
- rtu_global_flush = (state == FLUSH), decoded from the state register. It is high for exactly 1 cycle per flush event; a flush request seen during FLUSH or RECOVER is ignored.
- Create (combinational): create_acc = idu_create_req & (state == RUN) & ~rob_full & ~flush_trig, where flush_trig = |entry_flush_vld | ext_flush_req.
  - rob_create_sel = create_acc ? onehot(tail) : 0.
  - tail <= tail + 1 mod ENTRY_NUM on create_acc.
  - rob_full is the registered count, so a retire in the same cycle does not unblock a create when full.
- Retire: ret_acc = entry_retire_vld[head] & (state == RUN).
  - head <= head + 1 mod ENTRY_NUM on ret_acc. At most one retire per cycle.
  - Any entry_retire_vld bit set at a non-head index, or any retire while empty: ignored, and retire_err <= 1 (sticky until reset).
- Count update: cnt <= cnt + create_acc − ret_acc. Simultaneous create and retire leaves cnt unchanged.
- head_iid_ptr_cur_vld = onehot(head) in RUN; all zeros in FLUSH and RECOVER.
- FLUSH cycle: tail <= 0, head <= 0, cnt <= 0 at the end of the cycle. Entries self-clear on rtu_global_flush.
- rtu_idu_stall = rob_full | (state != RUN) | flush_trig.
- Wrap-around: pointers wrap modulo ENTRY_NUM. Full and empty are distinguished only by cnt, never by pointer equality.
- Latency:
  - Create is visible in entry_cnt 1 cycle later.
  - An entry flush_vld asserted in cycle N gives rtu_global_flush in N+1 and allocation possible again in N+3.

Test Plan:
- Reset held for 2 cycles during FLUSH → next cycle state RUN, entry_cnt = 0, rob_empty = 1, head_iid_ptr_cur_vld = 8'b0000_0001, rtu_global_flush = 0.
- 8 consecutive idu_create_req → rob_create_sel walks 0x01..0x80, rob_full = 1 after the 8th; 9th request gives rob_create_sel = 0, rtu_idu_stall = 1.
- Full ROB: retire entries 0–5, create 6 more → tail wraps to 6, head = 6, entry_cnt = 8, head_iid_ptr_cur_vld = 0x40.
- cnt = 3, create and head retire in the same cycle → entry_cnt stays 3, head and tail both advance by 1.
- entry_flush_vld[2] pulse in cycle N → rtu_global_flush = 1 only in N+1, rtu_idu_stall high N..N+2, head = tail = 0 and entry_cnt = 0 in N+2, create accepted in N+3 into entry 0.
- entry_retire_vld[5] while head = 2 → head unchanged, retire_err = 1, remains 1 until reset.
